// File: rtl/rob_mc_pkg.sv
// Shared definitions for the multi-commit reorder buffer.
//   - rob_type_e : entry type codes (bit 1 set means the entry writes rd)
//   - ROB_DEPTH_DEF : default number of entries
//   - rob_slot_t : per-slot flags handed to the commit selector
//   - writes_rd() : helper deciding whether a type updates the regfile
package rob_mc_pkg;

  typedef enum logic [1:0] {
    T_BR  = 2'b00,
    T_ST  = 2'b01,
    T_RD  = 2'b10,
    T_RDJ = 2'b11
  } rob_type_e;

  localparam int unsigned ROB_DEPTH_DEF = 16;

  typedef struct packed {
    logic      busy;
    logic      ready;
    rob_type_e typ;
    logic      pred_jmp;
    logic      res0;      // val[0] = resolved branch outcome
  } rob_slot_t;

  function automatic logic writes_rd(input rob_type_e t);
    return (t == T_RD) || (t == T_RDJ);
  endfunction

endpackage

// File: rtl/rob_mc_commit_sel.sv
// Commit slot selection for the reorder buffer.
//   head_slot/next_slot : flags of entry[head] and entry[head+1]
//   rdy, flush          : global stall and flush-in-progress
//   valid               : per-slot commit enable (bit 1 only when COMMIT_W=2)
//   store               : a store commits this cycle
//   br_valid, br_slot   : a branch commits, and in which slot
//   mispredict          : the committing branch disagrees with its prediction
module rob_commit_sel
  import rob_mc_pkg::*;
#(
  parameter int unsigned COMMIT_W = 2
) (
  input  rob_slot_t  head_slot,
  input  rob_slot_t  next_slot,
  input  logic       rdy,
  input  logic       flush,
  output logic [1:0] valid,
  output logic       store,
  output logic       br_valid,
  output logic       br_slot,
  output logic       mispredict
);

  logic br0, br1;

  always_comb begin
    valid      = '0;
    valid[0]   = head_slot.busy && head_slot.ready && rdy && !flush;
    // Second slot never follows a branch (one resolution per cycle) and
    // never pairs two stores (the LSB retires one store per cycle).
    if (COMMIT_W == 2) begin
      valid[1] = valid[0] && next_slot.busy && next_slot.ready
                 && (head_slot.typ != T_BR)
                 && !((head_slot.typ == T_ST) && (next_slot.typ == T_ST));
    end
    br0        = valid[0] && (head_slot.typ == T_BR);
    br1        = valid[1] && (next_slot.typ == T_BR);
    store      = (valid[0] && (head_slot.typ == T_ST)) ||
                 (valid[1] && (next_slot.typ == T_ST));
    br_valid   = br0 || br1;
    br_slot    = !br0;
    mispredict = 1'b0;
    if (br0)      mispredict = head_slot.res0 != head_slot.pred_jmp;
    else if (br1) mispredict = next_slot.res0 != next_slot.pred_jmp;
  end

endmodule

// File: rtl/rob_mc.sv
// Parametrised reorder buffer with N writeback ports and up to two
// in-order commits per cycle. Occupancy is tracked by a counter so all
// DEPTH entries are usable.
//   issue_*            : allocation at tail (alloc_id), issue_ready backpressure
//   wb_*               : flattened writeback ports (WB_PORTS x id/value)
//   commit_*           : per-slot commit strobes and data, commit_store to LSB
//   br_*               : committed branch info for the predictor
//   flush, flush_pc    : registered one-cycle mispredict redirect
//   q_id/q_avail/q_val : two operand lookups with same-cycle writeback bypass
//   head_id, count     : oldest entry and occupancy
module rob_mc
  import rob_mc_pkg::*;
#(
  parameter int unsigned DEPTH    = ROB_DEPTH_DEF,
  parameter int unsigned IDX_W    = $clog2(DEPTH),
  parameter int unsigned WB_PORTS = 2,
  parameter int unsigned COMMIT_W = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [1:0]                issue_type,
  input  logic [31:0]               issue_pc,
  input  logic [4:0]                issue_rd,
  input  logic                      issue_done,
  input  logic [31:0]               issue_result,
  input  logic                      issue_pred_jmp,
  input  logic [31:0]               issue_alt_pc,
  output logic [IDX_W-1:0]          alloc_id,
  input  logic [WB_PORTS-1:0]       wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0] wb_id,
  input  logic [WB_PORTS*32-1:0]    wb_val,
  output logic [IDX_W-1:0]          head_id,
  output logic [IDX_W:0]            count,
  output logic [COMMIT_W-1:0]       commit_valid,
  output logic [COMMIT_W*5-1:0]     commit_rd,
  output logic [COMMIT_W*32-1:0]    commit_val,
  output logic [COMMIT_W*IDX_W-1:0] commit_id,
  output logic                      commit_store,
  output logic                      br_valid,
  output logic [7:0]                br_pc_part,
  output logic                      br_taken,
  output logic                      flush,
  output logic [31:0]               flush_pc,
  input  logic [2*IDX_W-1:0]        q_id,
  output logic [1:0]                q_avail,
  output logic [63:0]               q_val
);

  logic [IDX_W-1:0] head, tail, head1, br_id;
  logic [IDX_W:0]   cnt, n_commit;
  logic [DEPTH-1:0] busy, ready, pred_q;
  rob_type_e        typ_q [DEPTH];
  logic [4:0]       rd_q  [DEPTH];
  logic [31:0]      val_q [DEPTH];
  logic [31:0]      alt_q [DEPTH];
  logic [31:0]      pc_q  [DEPTH];
  logic             flush_q;
  logic [31:0]      flush_pc_q;

  rob_slot_t  s0, s1;
  logic [1:0] sel_valid;
  logic       sel_store, sel_br, sel_br_slot, mispredict;
  logic       do_issue, wb_conflict;

  assign head1       = head + IDX_W'(1);
  assign issue_ready = (cnt != (IDX_W+1)'(DEPTH)) && !flush_q;
  assign do_issue    = issue_valid && issue_ready && rdy_in;
  assign n_commit    = (IDX_W+1)'(sel_valid[0]) + (IDX_W+1)'(sel_valid[1]);
  assign alloc_id    = tail;
  assign head_id     = head;
  assign count       = cnt;
  assign flush       = flush_q;
  assign flush_pc    = flush_pc_q;

  always_comb begin
    s0 = '{busy: busy[head], ready: ready[head], typ: typ_q[head],
           pred_jmp: pred_q[head], res0: val_q[head][0]};
    s1 = '{busy: busy[head1], ready: ready[head1], typ: typ_q[head1],
           pred_jmp: pred_q[head1], res0: val_q[head1][0]};
  end

  rob_commit_sel #(.COMMIT_W(COMMIT_W)) u_sel (
    .head_slot  (s0),
    .next_slot  (s1),
    .rdy        (rdy_in),
    .flush      (flush_q),
    .valid      (sel_valid),
    .store      (sel_store),
    .br_valid   (sel_br),
    .br_slot    (sel_br_slot),
    .mispredict (mispredict)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      busy       <= '0;
      ready      <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else if (rdy_in) begin
      if (flush_q) begin
        head    <= '0;
        tail    <= '0;
        cnt     <= '0;
        busy    <= '0;
        ready   <= '0;
        flush_q <= 1'b0;
      end else begin
        // Later ports overwrite earlier ones on a collision.
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
          if (wb_valid[p] && busy[wb_id[p*IDX_W +: IDX_W]]) begin
            ready[wb_id[p*IDX_W +: IDX_W]] <= 1'b1;
            val_q[wb_id[p*IDX_W +: IDX_W]] <= wb_val[p*32 +: 32];
          end
        end
        // Commit clears after writeback so a late result to a retiring
        // entry cannot resurrect it.
        if (sel_valid[0]) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
        end
        if (sel_valid[1]) begin
          busy[head1]  <= 1'b0;
          ready[head1] <= 1'b0;
        end
        if (do_issue) begin
          busy[tail]   <= 1'b1;
          ready[tail]  <= issue_done;
          typ_q[tail]  <= rob_type_e'(issue_type);
          rd_q[tail]   <= issue_rd;
          val_q[tail]  <= issue_result;
          pred_q[tail] <= issue_pred_jmp;
          alt_q[tail]  <= issue_alt_pc;
          pc_q[tail]   <= issue_pc;
        end
        if (mispredict) begin
          flush_q    <= 1'b1;
          flush_pc_q <= sel_br_slot ? alt_q[head1] : alt_q[head];
        end
        head <= head + n_commit[IDX_W-1:0];
        tail <= tail + IDX_W'(do_issue);
        cnt  <= cnt + (IDX_W+1)'(do_issue) - n_commit;
      end
    end
  end

  always_comb begin
    logic [IDX_W-1:0] sid;
    sid          = '0;
    commit_valid = sel_valid[COMMIT_W-1:0];
    commit_rd    = '0;
    commit_val   = '0;
    commit_id    = '0;
    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      sid = (k == 0) ? head : head1;
      if (sel_valid[k]) begin
        commit_id[k*IDX_W +: IDX_W] = sid;
        commit_rd[k*5 +: 5]         = writes_rd(typ_q[sid]) ? rd_q[sid] : 5'd0;
        commit_val[k*32 +: 32]      = val_q[sid];
      end
    end
    commit_store = sel_store;
    br_valid     = sel_br;
    br_id        = sel_br_slot ? head1 : head;
    br_pc_part   = sel_br ? pc_q[br_id][8:1] : 8'd0;
    br_taken     = sel_br && val_q[br_id][0];
  end

  // Stored value has priority; otherwise the lowest-index matching port.
  always_comb begin
    logic [IDX_W-1:0] qi;
    logic             hit;
    logic [31:0]      bv;
    qi      = '0;
    hit     = 1'b0;
    bv      = '0;
    q_avail = '0;
    q_val   = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      qi  = q_id[i*IDX_W +: IDX_W];
      hit = 1'b0;
      bv  = '0;
      for (int unsigned p = 0; p < WB_PORTS; p++) begin
        if (!hit && wb_valid[p] && (wb_id[p*IDX_W +: IDX_W] == qi)) begin
          hit = 1'b1;
          bv  = wb_val[p*32 +: 32];
        end
      end
      q_avail[i]       = ready[qi] || hit;
      q_val[i*32 +: 32] = ready[qi] ? val_q[qi] : bv;
    end
  end

  always_comb begin
    wb_conflict = 1'b0;
    for (int unsigned a = 0; a < WB_PORTS; a++) begin
      for (int unsigned b = a + 1; b < WB_PORTS; b++) begin
        if (wb_valid[a] && wb_valid[b] &&
            (wb_id[a*IDX_W +: IDX_W] == wb_id[b*IDX_W +: IDX_W]))
          wb_conflict = 1'b1;
      end
    end
  end

  // Two ports targeting one entry in the same cycle is a protocol error.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && rdy_in) assert (!wb_conflict);
  end

endmodule
